// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator sequencer and its command FIFO.
package alu_pkg;

  localparam int WIDTH = 16;

  // ALU opcodes
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MIN  = 3'b010;
  localparam logic [2:0] OP_MAX  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  // Command kinds
  localparam logic [1:0] KIND_LOAD  = 2'b00;
  localparam logic [1:0] KIND_EXEC  = 2'b01;
  localparam logic [1:0] KIND_PEEK  = 2'b10;
  localparam logic [1:0] KIND_CLEAR = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_OUT  = 2'b10
  } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with wrap-around pointers and an explicit occupancy count.
module alu_cmd_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and count; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_acc_seq.sv
// Command-driven accumulator sequencer feeding an external combinational ALU.
//
// state | meaning
// IDLE  | waiting for a buffered command; pops the head into the exec registers
// EXEC  | ALU inputs are stable; commit acc and/or capture the result
// OUT   | result presented on res_*; held until res_ready
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic             res_zero
);

  localparam int ENTRY_W = 2 + 3 + WIDTH;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  logic [1:0]         head_kind;
  logic [2:0]         head_op;
  logic [WIDTH-1:0]   head_data;

  state_t             state;
  logic [1:0]         ex_kind;
  logic [WIDTH-1:0]   acc;

  assign cmd_ready = (fifo_count < CNT_W'(DEPTH));
  assign push      = cmd_valid & ~fifo_full;
  assign pop       = (state == ST_IDLE) & ~fifo_empty;

  assign {head_kind, head_op, head_data} = head;

  alu_cmd_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({cmd_kind, cmd_op, cmd_data}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequencer FSM; alu_b/alu_op double as the exec data/op registers and alu_a shadows acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ex_kind   <= KIND_LOAD;
      acc       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= OP_ADD;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
      res_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            ex_kind <= head_kind;
            alu_op  <= head_op;
            alu_b   <= head_data;
            alu_a   <= acc;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (ex_kind)
            KIND_LOAD: begin
              acc   <= alu_b;
              alu_a <= alu_b;
              state <= ST_IDLE;
            end
            KIND_CLEAR: begin
              acc   <= '0;
              alu_a <= '0;
              state <= ST_IDLE;
            end
            KIND_EXEC: begin
              acc       <= alu_y;
              alu_a     <= alu_y;
              res_data  <= alu_y;
              res_cout  <= alu_cout;
              res_zero  <= (alu_y == '0);
              res_valid <= 1'b1;
              state     <= ST_OUT;
            end
            default: begin
              res_data  <= acc;
              res_cout  <= 1'b0;
              res_zero  <= (acc == '0);
              res_valid <= 1'b1;
              state     <= ST_OUT;
            end
          endcase
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq with a behavioural 16-bit ALU in the parent position.
module tb_alu_acc_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_kind;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_y;
  logic        alu_cout;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_cout;
  logic        res_zero;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_acc_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_kind  (cmd_kind),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .alu_cout  (alu_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cout  (res_cout),
    .res_zero  (res_zero)
  );

  // External ALU
  always_comb begin
    alu_y    = '0;
    alu_cout = 1'b0;
    case (alu_op)
      OP_ADD:  {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  alu_y = alu_a - alu_b;
      OP_MIN:  alu_y = (alu_a < alu_b) ? alu_a : alu_b;
      OP_MAX:  alu_y = (alu_a > alu_b) ? alu_a : alu_b;
      OP_AND:  alu_y = alu_a & alu_b;
      OP_OR:   alu_y = alu_a | alu_b;
      OP_XOR:  alu_y = alu_a ^ alu_b;
      default: alu_y = ~(alu_a ^ alu_b);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one command and return just after the edge that accepts it; cmd_valid stays high.
  task automatic send(input logic [1:0] kind, input logic [2:0] op, input logic [15:0] data);
    logic accepted;
    accepted  = 1'b0;
    cmd_kind  = kind;
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    for (int i = 0; i < 60 && !accepted; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end
    end
    check("send_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
  endtask

  // Wait for a result, compare it, and let res_ready consume it on the next edge.
  task automatic recv(input string tag, input logic [15:0] exp_data,
                      input logic exp_cout, input logic exp_zero);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_data"},  32'(res_data),  32'(exp_data));
    check({tag, "_cout"},  32'(res_cout),  32'(exp_cout));
    check({tag, "_zero"},  32'(res_zero),  32'(exp_zero));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_kind  = KIND_LOAD;
    cmd_op    = OP_ADD;
    cmd_data  = '0;
    res_ready = 1'b1;

    // Reset state
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_res_cout",  32'(res_cout),  32'd0);
    check("rst_res_zero",  32'(res_zero),  32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_alu_b",     32'(alu_b),     32'd0);
    check("rst_alu_op",    32'(alu_op),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);

    // ADD with carry out, then PEEK of the wrapped accumulator
    send(KIND_LOAD, OP_ADD, 16'hFFFF);
    send(KIND_EXEC, OP_ADD, 16'h0001);
    idle_cmd();
    recv("add_carry", 16'h0000, 1'b1, 1'b1);
    send(KIND_PEEK, OP_ADD, 16'h0000);
    idle_cmd();
    recv("peek_after_add", 16'h0000, 1'b0, 1'b1);

    // SUB wraps modulo 2^16
    send(KIND_LOAD, OP_ADD, 16'h0005);
    send(KIND_EXEC, OP_SUB, 16'h0007);
    idle_cmd();
    recv("sub_wrap", 16'hFFFE, 1'b0, 1'b0);

    // Latency from idle with acc = 0x1234, then MIN and MAX
    send(KIND_LOAD, OP_ADD, 16'h1234);
    idle_cmd();
    wait_cycles(4);
    check("lat_alu_a_load", 32'(alu_a), 32'h1234);
    send(KIND_EXEC, OP_MIN, 16'h00FF);
    idle_cmd();
    @(negedge clk);
    check("lat_n1_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("lat_n2_valid", 32'(res_valid), 32'd0);
    check("lat_n2_alu_b", 32'(alu_b), 32'h00FF);
    check("lat_n2_alu_op", 32'(alu_op), 32'(OP_MIN));
    @(negedge clk);
    check("lat_n3_valid", 32'(res_valid), 32'd1);
    check("lat_n3_data",  32'(res_data),  32'h00FF);
    @(posedge clk);
    #1;
    send(KIND_EXEC, OP_MAX, 16'h8000);
    idle_cmd();
    recv("max", 16'h8000, 1'b0, 1'b0);

    // Backpressure: five commands fill the pipeline, the sixth waits for space
    send(KIND_CLEAR, OP_ADD, 16'h0000);
    idle_cmd();
    wait_cycles(3);
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(KIND_EXEC, OP_ADD, 16'h0001);
    cmd_data = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
      check("bp_res_valid_held", 32'(res_valid), 32'd1);
      check("bp_res_data_held", 32'(res_data), 32'h0001);
    end
    @(posedge clk);
    #1;
    fork
      begin
        send(KIND_EXEC, OP_ADD, 16'h0001);
        idle_cmd();
      end
      begin
        res_ready = 1'b1;
        for (int k = 1; k <= 6; k++) recv("bp_result", 16'(k), 1'b0, 1'b0);
      end
    join

    // CLEAR then PEEK
    send(KIND_LOAD, OP_ADD, 16'hAAAA);
    send(KIND_CLEAR, OP_ADD, 16'h0000);
    send(KIND_PEEK, OP_ADD, 16'h0000);
    idle_cmd();
    recv("clear_peek", 16'h0000, 1'b0, 1'b1);

    // Reset while a LOAD is executing with more commands queued
    send(KIND_LOAD, OP_ADD, 16'h5555);
    send(KIND_EXEC, OP_ADD, 16'h0001);
    cmd_kind = KIND_PEEK;
    check("pre_rst_alu_b", 32'(alu_b), 32'h5555);
    rst = 1'b1;
    #2;
    check("mid_rst_alu_a",     32'(alu_a),     32'd0);
    check("mid_rst_alu_b",     32'(alu_b),     32'd0);
    check("mid_rst_alu_op",    32'(alu_op),    32'd0);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_res_data",  32'(res_data),  32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    idle_cmd();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_result", 32'(res_valid), 32'd0);
    end
    check("post_rst_alu_a", 32'(alu_a), 32'd0);
    @(posedge clk);
    #1;
    send(KIND_PEEK, OP_ADD, 16'h0000);
    idle_cmd();
    recv("post_rst_peek", 16'h0000, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_acc_seq.md
# alu_acc_seq

Command-driven accumulator sequencer placed directly upstream of the 16-bit combinational ALU. It buffers incoming commands in a 4-entry FIFO and drives the ALU's `a`, `b` and `op` inputs from registers. The ALU output is captured into a 16-bit accumulator, and results are returned on a valid/ready handshake with carry and zero flags.

## Interface
- `WIDTH`, 16, datapath width; matches the ALU.
- `DEPTH`, 4, command FIFO depth; power of two.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full.
- `cmd_kind` in 2: 00 LOAD, 01 EXEC, 10 PEEK, 11 CLEAR.
- `cmd_op` in 3: ALU opcode, used by EXEC only.
- `cmd_data` in WIDTH: operand.
- `alu_a` out WIDTH: to ALU `a`; registered, equals acc.
- `alu_b` out WIDTH: to ALU `b`; registered operand.
- `alu_op` out 3: to ALU `op`; registered.
- `alu_y` in WIDTH: from ALU `y`.
- `alu_cout` in 1: from ALU `cout`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts.
- `res_data` out WIDTH: result value.
- `res_cout` out 1: carry flag.
- `res_zero` out 1: result equals 0.

## Operation
- **Command acceptance:** a command is accepted when `cmd_valid & cmd_ready`, and is pushed into the FIFO.
- **`cmd_ready`:** equals FIFO count < DEPTH.
- **Simultaneous push and pop:** count is unchanged.
- **FSM states:** IDLE, EXEC, OUT.
- **IDLE:**
  - If the FIFO is non-empty, pop the head into the exec registers (kind, op, data) and go to EXEC.
  - At the same edge, `alu_b` takes data, `alu_op` takes op, and `alu_a` takes acc.
- **EXEC, by kind:**
  - LOAD: acc <= data; go to IDLE; no result.
  - CLEAR: acc <= 0; go to IDLE; no result.
  - EXEC: acc <= `alu_y`; `res_data` <= `alu_y`; `res_cout` <= `alu_cout`; `res_zero` <= (`alu_y`==0); go to OUT.
  - PEEK: `res_data` <= acc; `res_cout` <= 0; `res_zero` <= (acc==0); acc unchanged; go to OUT.
- **OUT:**
  - `res_valid`=1, and `res_*` are held stable.
  - On `res_ready`, go to IDLE.
  - The FIFO keeps accepting commands while in OUT.
- **`alu_a`:** follows acc at every acc update, so the ALU always sees the current accumulator.
- **Arithmetic:** performed entirely in the ALU; this block never modifies `alu_y`.
  - `cout` is meaningful only for op 000 (ADD); the ALU forces it to 0 for all other ops.
  - SUB wraps modulo 2^16.
- **Ordering:** commands execute strictly in acceptance order; results are returned in order.

## Timing
- **Reset values:**
  - `cmd_ready`=1 (FIFO empty).
  - `res_valid`=0, `res_data`=0, `res_cout`=0, `res_zero`=0.
  - `alu_a`=0, `alu_b`=0, `alu_op`=0.
  - acc=0, state IDLE.
- **Reset mid-operation:** asserting `rst` at any time discards FIFO contents, the in-flight command and any pending result. No partial acc update.
- **Latency:** command accepted in cycle N is popped in N+1, executed in N+2, and `res_valid` is high from N+3 (when the FSM is idle and the FIFO is empty).
- **Throughput:**
  - Best case is one result per 3 cycles with `res_ready`=1.
  - LOAD/CLEAR occupy 2 cycles.
- **Backpressure:**
  - `res_valid` stays high until `res_ready`, with the FSM held in OUT.
  - The FIFO fills, and `cmd_ready` drops in the cycle after the DEPTH-th buffered entry is written.
- **Full FIFO:** `cmd_valid` while `cmd_ready`=0 is ignored; there is no overflow.
- **Empty FIFO:** IDLE holds and the exec registers are unchanged.
- **FIFO pointers:** log2(DEPTH)-bit wrap-around; count is log2(DEPTH)+1 bits.

## Structure
- **Shared package `alu_pkg`:**
  - WIDTH constant.
  - ALU opcode constants: ADD=000, SUB=001, MIN=010, MAX=011, AND=100, OR=101, XOR=110, XNOR=111.
  - `cmd_kind` constants.
  - FSM state enum.
- **Sub-module `alu_cmd_fifo`:** synchronous FIFO of {kind, op, data}, parameterised by width and DEPTH, with count/full/empty outputs. The sequencer instantiates it.
- **ALU:** instantiated outside this block, in the parent, and connected via the `alu_*` ports.

## Test plan
- **ADD carry:** LOAD 0xFFFF, then EXEC op 000 data 0x0001.
  - Response: `res_data`=0x0000, `res_cout`=1, `res_zero`=1.
  - A following PEEK returns 0x0000.
- **SUB wrap:** LOAD 0x0005, then EXEC op 001 data 0x0007.
  - Response: `res_data`=0xFFFE, `res_cout`=0, `res_zero`=0.
- **Latency and MIN/MAX:** from an idle state with acc 0x1234:
  - EXEC op 010 data 0x00FF accepted in cycle N gives `res_valid` first high in N+3 with 0x00FF.
  - Then EXEC op 011 data 0x8000 gives 0x8000.
- **Backpressure/full:** acc=0, `res_ready`=0, push six EXEC ADD 0x0001 back-to-back.
  - `cmd_ready` goes low with the sixth command pending.
  - Raising `res_ready` yields results 1,2,3,4,5,6 in order.
  - The sixth command is accepted once space frees.
- **CLEAR/PEEK/reset:**
  - LOAD 0xAAAA, CLEAR, PEEK gives 0x0000 with `res_zero`=1.
  - Then queue 3 commands and assert `rst` during EXEC: all outputs return to reset values and no results appear afterward.
